// File: rtl/mag_scheduler_pkg.sv
// Shared definitions for the waterfall magnitude scheduler: FSM state
// encodings and pixel format constants.
package mag_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAT  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int PIX_W   = 8;
  localparam int PIX_MAX = 255;

endpackage

// File: rtl/mag_scheduler_abs.sv
// Complex magnitude approximation |re| + |im|, saturated to width bits.
// Purely combinational; the scheduler registers its inputs one cycle earlier.
module mag_scheduler_abs #(
  parameter int width = 16
) (
  input  logic [width-1:0] re,
  input  logic [width-1:0] im,
  output logic [width-1:0] mag
);

  logic [width-1:0] abs_re;
  logic [width-1:0] abs_im;
  logic [width:0]   sum;

  // Two's-complement absolute values; the most negative input maps to 2**(width-1) unsigned
  always_comb begin
    abs_re = re[width-1] ? (~re + 1'b1) : re;
    abs_im = im[width-1] ? (~im + 1'b1) : im;
    sum    = {1'b0, abs_re} + {1'b0, abs_im};
    mag    = sum[width] ? '1 : sum[width-1:0];
  end

endmodule

// File: rtl/mag_scheduler.sv
// Sequences one FFT frame through the shared magnitude unit and writes one
// 8-bit waterfall line. Each bin takes RD -> LAT -> WR; WR holds until the
// line buffer accepts the pixel.
// Optional feature: define PEAK_HOLD_EN to add peak_mag/peak_bin outputs
// reporting the largest raw magnitude of the last completed line.
module mag_scheduler
  import mag_scheduler_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NBINS  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        shift,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bin_addr,
  input  logic [WIDTH-1:0]  bin_re,
  input  logic [WIDTH-1:0]  bin_im,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready
`ifdef PEAK_HOLD_EN
  ,
  output logic [WIDTH-1:0]  peak_mag,
  output logic [ADDR_W-1:0] peak_bin
`endif
);

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] bin_idx;
  logic [WIDTH-1:0]  re_q;
  logic [WIDTH-1:0]  im_q;
  logic [3:0]        shift_q;
  logic [WIDTH-1:0]  mag;
  logic [WIDTH-1:0]  scaled;
  logic [PIX_W-1:0]  pix_sat;
  logic              last_bin;
  logic              handshake;

  assign last_bin  = (bin_idx == ADDR_W'(NBINS - 1));
  assign handshake = (state == S_WR) && pix_ready;
  assign bin_addr  = bin_idx;
  assign pix_addr  = bin_idx;

  mag_scheduler_abs #(.width(WIDTH)) abs_0 (
    .re  (re_q),
    .im  (im_q),
    .mag (mag)
  );

  // Scale the raw magnitude by the latched shift and clamp it to a pixel
  always_comb begin
    scaled  = mag >> shift_q;
    pix_sat = (scaled > WIDTH'(PIX_MAX)) ? PIX_W'(PIX_MAX) : scaled[PIX_W-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state and output decode; pixel data only shows while a write is offered
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_RD;
      end
      S_RD: begin
        busy       = 1'b1;
        next_state = S_LAT;
      end
      S_LAT: begin
        busy       = 1'b1;
        next_state = S_WR;
      end
      S_WR: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        pix_data  = pix_sat;
        if (pix_ready) next_state = last_bin ? S_DONE : S_RD;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Bin counter, shift latch and RAM data capture into the magnitude unit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_idx <= '0;
      re_q    <= '0;
      im_q    <= '0;
      shift_q <= '0;
    end else begin
      if (state == S_IDLE && start) shift_q <= shift;
      if (state == S_LAT) begin
        re_q <= bin_re;
        im_q <= bin_im;
      end
      if (handshake) begin
        if (last_bin) bin_idx <= '0;
        else          bin_idx <= bin_idx + 1'b1;
      end
    end
  end

`ifdef PEAK_HOLD_EN
  logic [WIDTH-1:0]  run_max;
  logic [ADDR_W-1:0] run_bin;
  logic              new_peak;

  assign new_peak = (mag > run_max);

  // Running peak over the line; strict compare keeps the lowest bin on ties,
  // and the final bin is folded in as the result is published at line end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_max  <= '0;
      run_bin  <= '0;
      peak_mag <= '0;
      peak_bin <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        run_max <= '0;
        run_bin <= '0;
      end else if (handshake && new_peak) begin
        run_max <= mag;
        run_bin <= bin_idx;
      end
      if (handshake && last_bin) begin
        peak_mag <= new_peak ? mag : run_max;
        peak_bin <= new_peak ? bin_idx : run_bin;
      end
    end
  end
`else
  // Peak tracking not built in this configuration
`endif

endmodule

// File: tb/tb_mag_scheduler.sv
// Self-checking bench for mag_scheduler. A registered-read RAM model feeds
// bins; a negedge monitor logs accepted pixel writes and done pulses, which
// each test compares with a magnitude/scale reference computed in plain
// integer arithmetic. Define PEAK_HOLD_EN to also exercise peak tracking.
module tb_mag_scheduler;

  localparam int WIDTH  = 16;
  localparam int NBINS  = 64;
  localparam int ADDR_W = 6;
  localparam int LINE_CYCLES = 3 * NBINS + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [3:0]        shift;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bin_addr;
  logic [WIDTH-1:0]  bin_re;
  logic [WIDTH-1:0]  bin_im;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              pix_ready;
`ifdef PEAK_HOLD_EN
  logic [WIDTH-1:0]  peak_mag;
  logic [ADDR_W-1:0] peak_bin;
`endif

  int ram_re[NBINS];
  int ram_im[NBINS];
  int wr_addr_q[$];
  int wr_data_q[$];
  int done_cnt = 0;
  int checks = 0;
  int errors = 0;

  mag_scheduler #(.WIDTH(WIDTH), .NBINS(NBINS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .shift     (shift),
    .busy      (busy),
    .done      (done),
    .bin_addr  (bin_addr),
    .bin_re    (bin_re),
    .bin_im    (bin_im),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready)
`ifdef PEAK_HOLD_EN
    ,
    .peak_mag  (peak_mag),
    .peak_bin  (peak_bin)
`endif
  );

  always #5 clk = ~clk;

  // FFT result RAM: read data valid one cycle after the address
  always @(posedge clk) begin
    bin_re <= ram_re[bin_addr][15:0];
    bin_im <= ram_im[bin_addr][15:0];
  end

  // Log accepted writes and done pulses midway between clock edges
  always @(negedge clk) begin
    if (reset_n === 1'b1 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
      wr_addr_q.push_back(int'(pix_addr));
      wr_data_q.push_back(int'(pix_data));
    end
    if (done === 1'b1) done_cnt++;
  end

  // Reference: magnitude = |re| + |im| capped at 16 bits, shifted, clamped to 255
  function automatic int expected_pix(int i, int sh);
    int a;
    int s;
    a = (ram_re[i] < 0 ? -ram_re[i] : ram_re[i]) + (ram_im[i] < 0 ? -ram_im[i] : ram_im[i]);
    if (a > 65535) a = 65535;
    s = a >> sh;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int ref_mag(int i);
    int a;
    a = (ram_re[i] < 0 ? -ram_re[i] : ram_re[i]) + (ram_im[i] < 0 ? -ram_im[i] : ram_im[i]);
    return (a > 65535) ? 65535 : a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(int maxmag);
    for (int i = 0; i < NBINS; i++) begin
      ram_re[i] = int'($urandom_range(0, 2 * maxmag)) - maxmag;
      ram_im[i] = int'($urandom_range(0, 2 * maxmag)) - maxmag;
    end
  endtask

  task automatic begin_line(int sh);
    wr_addr_q.delete();
    wr_data_q.delete();
    start = 1'b1;
    shift = 4'(sh);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, input bit noise, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 5000) begin
      if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
      if (noise) begin
        start = ($urandom_range(0, 4) == 0);
        shift = 4'($urandom_range(0, 15));
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    shift = 4'd0;
    pix_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, pix_valid, bin_addr, pix_addr, pix_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b valid=%b baddr=%0d paddr=%0d data=%0d, required all 0",
               busy, done, pix_valid, bin_addr, pix_addr, pix_data);
    end
`ifdef PEAK_HOLD_EN
    checks++;
    if (peak_mag !== '0 || peak_bin !== '0) begin
      errors++;
      $display("[TB] FAIL reset_peak: mag=%0d bin=%0d, required 0 0", peak_mag, peak_bin);
    end
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_const_line();
    int cyc;
    for (int i = 0; i < NBINS; i++) begin
      ram_re[i] = 2000;
      ram_im[i] = 0;
    end
    begin_line(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: busy=%b, required 1", busy);
    end
    wait_done(1'b0, 1'b0, cyc);
    checks++;
    if (cyc != LINE_CYCLES) begin
      errors++;
      $display("[TB] FAIL line_latency: done at cycle %0d, required %0d", cyc, LINE_CYCLES);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_at_done: busy=%b, required 0", busy);
    end
    checks++;
    if (wr_addr_q.size() != NBINS) begin
      errors++;
      $display("[TB] FAIL const_count: writes=%0d, required %0d", wr_addr_q.size(), NBINS);
    end
    for (int i = 0; i < NBINS && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != 250) begin
        errors++;
        $display("[TB] FAIL const_pix: write %0d addr=%0d data=%0d, required addr=%0d data=250",
                 i, wr_addr_q[i], wr_data_q[i], i);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    int cyc;
    fill_random(1000);
    ram_re[7] = -5800;
    ram_im[7] = 0;
    begin_line(4);
    wait_done(1'b0, 1'b0, cyc);
    checks++;
    if (wr_data_q.size() != NBINS || wr_data_q[7] != 255) begin
      errors++;
      $display("[TB] FAIL sat_bin7: writes=%0d data=%0d, required %0d writes, data=255",
               wr_data_q.size(), (wr_data_q.size() > 7) ? wr_data_q[7] : -1, NBINS);
    end
    for (int i = 0; i < NBINS && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != expected_pix(i, 4)) begin
        errors++;
        $display("[TB] FAIL sat_line: write %0d addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, wr_addr_q[i], wr_data_q[i], i, expected_pix(i, 4));
      end
    end
    tick();
    ram_re[7] = 0;
    ram_im[7] = -16;
    begin_line(0);
    wait_done(1'b0, 1'b0, cyc);
    checks++;
    if (wr_data_q.size() != NBINS || wr_data_q[7] != 16) begin
      errors++;
      $display("[TB] FAIL neg_imag_bin7: writes=%0d data=%0d, required %0d writes, data=16",
               wr_data_q.size(), (wr_data_q.size() > 7) ? wr_data_q[7] : -1, NBINS);
    end
    tick();
  endtask

  task automatic test_random_lines();
    int cyc;
    int sh;
    for (int l = 0; l < 3; l++) begin
      fill_random(32768);
      if (l == 0) ram_re[0] = -32768;
      sh = int'($urandom_range(0, 15));
      begin_line(sh);
      wait_done(1'b1, 1'b0, cyc);
      checks++;
      if (wr_addr_q.size() != NBINS) begin
        errors++;
        $display("[TB] FAIL rand_count: line %0d writes=%0d, required %0d", l, wr_addr_q.size(), NBINS);
      end
      for (int i = 0; i < NBINS && i < wr_addr_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] != i || wr_data_q[i] != expected_pix(i, sh)) begin
          errors++;
          $display("[TB] FAIL rand_pix: line %0d write %0d addr=%0d data=%0d, required addr=%0d data=%0d",
                   l, i, wr_addr_q[i], wr_data_q[i], i, expected_pix(i, sh));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int cyc;
    int n;
    fill_random(3000);
    begin_line(2);
    n = 0;
    while (!(pix_valid === 1'b1 && pix_addr == ADDR_W'(2)) && n < 100) begin
      tick();
      n++;
    end
    pix_ready = 1'b0;
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL stall_reach_bin2: pix_valid=%b pix_addr=%0d, required 1 and 2", pix_valid, pix_addr);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (pix_valid !== 1'b1 || pix_addr !== ADDR_W'(2) || int'(pix_data) != expected_pix(2, 2)) begin
        errors++;
        $display("[TB] FAIL stall_hold: cycle %0d valid=%b addr=%0d data=%0d, required 1 2 %0d",
                 c, pix_valid, pix_addr, pix_data, expected_pix(2, 2));
      end
    end
    pix_ready = 1'b1;
    wait_done(1'b0, 1'b0, cyc);
    checks++;
    if (wr_addr_q.size() != NBINS) begin
      errors++;
      $display("[TB] FAIL stall_count: writes=%0d, required %0d", wr_addr_q.size(), NBINS);
    end
    for (int i = 0; i < NBINS && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != expected_pix(i, 2)) begin
        errors++;
        $display("[TB] FAIL stall_pix: write %0d addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, wr_addr_q[i], wr_data_q[i], i, expected_pix(i, 2));
      end
    end
    tick();
  endtask

  task automatic test_ignore_inputs();
    int cyc;
    int d0;
    fill_random(8000);
    d0 = done_cnt;
    begin_line(2);
    wait_done(1'b1, 1'b1, cyc);
    tick();
    tick();
    tick();
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_done_count: done pulses=%0d busy=%b, required 1 and 0", done_cnt - d0, busy);
    end
    checks++;
    if (wr_addr_q.size() != NBINS) begin
      errors++;
      $display("[TB] FAIL ignore_count: writes=%0d, required %0d", wr_addr_q.size(), NBINS);
    end
    for (int i = 0; i < NBINS && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != expected_pix(i, 2)) begin
        errors++;
        $display("[TB] FAIL ignore_pix: write %0d addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, wr_addr_q[i], wr_data_q[i], i, expected_pix(i, 2));
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_random(2000);
    begin_line(2);
    wait_done(1'b0, 1'b0, cyc);
    start = 1'b1;
    shift = 4'd1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: busy=%b done=%b, required 0 0", busy, done);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: busy=%b, required 1", busy);
    end
    wait_done(1'b0, 1'b0, cyc);
    checks++;
    if (cyc != LINE_CYCLES || wr_addr_q.size() != NBINS) begin
      errors++;
      $display("[TB] FAIL b2b_line: done cycle=%0d writes=%0d, required %0d and %0d",
               cyc, wr_addr_q.size(), LINE_CYCLES, NBINS);
    end
    for (int i = 0; i < NBINS && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != expected_pix(i, 1)) begin
        errors++;
        $display("[TB] FAIL b2b_pix: write %0d addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, wr_addr_q[i], wr_data_q[i], i, expected_pix(i, 1));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_line();
    int cyc;
    int n;
    int d0;
    fill_random(4000);
    begin_line(3);
    n = 0;
    while (!(pix_valid === 1'b1 && pix_addr == ADDR_W'(5)) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("[TB] FAIL midreset_reach_bin5: pix_valid=%b pix_addr=%0d, required 1 and 5", pix_valid, pix_addr);
    end
    d0 = done_cnt;
    reset_n = 1'b0;
    pix_ready = 1'b0;
    tick();
    checks++;
    if ({busy, done, pix_valid, bin_addr, pix_addr, pix_data} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: busy=%b done=%b valid=%b baddr=%0d paddr=%0d data=%0d, required all 0",
               busy, done, pix_valid, bin_addr, pix_addr, pix_data);
    end
    reset_n = 1'b1;
    pix_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("[TB] FAIL midreset_no_done: done pulses=%0d, required 0", done_cnt - d0);
    end
    begin_line(3);
    wait_done(1'b0, 1'b0, cyc);
    checks++;
    if (wr_addr_q.size() != NBINS || wr_addr_q[0] != 0) begin
      errors++;
      $display("[TB] FAIL midreset_restart: writes=%0d first addr=%0d, required %0d and 0",
               wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, NBINS);
    end
    for (int i = 0; i < NBINS && i < wr_addr_q.size(); i++) begin
      checks++;
      if (wr_addr_q[i] != i || wr_data_q[i] != expected_pix(i, 3)) begin
        errors++;
        $display("[TB] FAIL midreset_pix: write %0d addr=%0d data=%0d, required addr=%0d data=%0d",
                 i, wr_addr_q[i], wr_data_q[i], i, expected_pix(i, 3));
      end
    end
    tick();
  endtask

`ifdef PEAK_HOLD_EN
  task automatic test_peak();
    int cyc;
    int pk;
    int pb;
    for (int i = 0; i < NBINS; i++) begin
      ram_re[i] = 100;
      ram_im[i] = 0;
    end
    ram_re[3] = 4000;
    ram_re[9] = 4000;
    begin_line(0);
    wait_done(1'b0, 1'b0, cyc);
    tick();
    checks++;
    if (peak_mag !== 16'd4000 || peak_bin !== ADDR_W'(3)) begin
      errors++;
      $display("[TB] FAIL peak_fixed: mag=%0d bin=%0d, required 4000 3", peak_mag, peak_bin);
    end
    fill_random(20000);
    pk = 0;
    pb = 0;
    for (int i = 0; i < NBINS; i++) if (ref_mag(i) > pk) begin pk = ref_mag(i); pb = i; end
    begin_line(5);
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if (peak_mag !== 16'd4000 || peak_bin !== ADDR_W'(3)) begin
      errors++;
      $display("[TB] FAIL peak_hold: mag=%0d bin=%0d, required 4000 3", peak_mag, peak_bin);
    end
    wait_done(1'b1, 1'b0, cyc);
    tick();
    checks++;
    if (int'(peak_mag) != pk || int'(peak_bin) != pb) begin
      errors++;
      $display("[TB] FAIL peak_random: mag=%0d bin=%0d, required %0d %0d", peak_mag, peak_bin, pk, pb);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_const_line();
    test_saturation();
    test_random_lines();
    test_stall();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_mid_line();
`ifdef PEAK_HOLD_EN
    test_peak();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
